// File: rtl/expmod_uart_pkg.sv
// Shared constants and state encoding for the UART front-end of the
// modular-exponentiation engine.
package expmod_uart_pkg;

    localparam logic [7:0] DEFAULT_SYNC  = 8'hA5;

    localparam logic [7:0] OP_FULL       = 8'h01;
    localparam logic [7:0] OP_VALUE      = 8'h02;

    localparam logic [7:0] ST_OK         = 8'h00;
    localparam logic [7:0] ST_BAD_OPCODE = 8'hE1;
    localparam logic [7:0] ST_ZERO_MOD   = 8'hE2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPCODE,
        S_RX_OPS,
        S_LAUNCH,
        S_WAIT,
        S_TX_SYNC,
        S_TX_STATUS,
        S_TX_DATA
    } state_t;

endpackage

// File: rtl/byte_shift_assembler.sv
// WIDTH-bit staging register that shifts in one byte at a time, MSB byte
// first. Bits pushed above WIDTH fall off, so pad bits of the first byte
// of an operand never reach the word.
module byte_shift_assembler #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [7:0]       byte_in,
    output logic [WIDTH-1:0] word
);

    // Clear at the start of a frame, otherwise shift the new byte in at the LSB end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word <= '0;
        end else if (clear) begin
            word <= '0;
        end else if (load) begin
            word <= WIDTH'({word, byte_in});
        end
    end

endmodule

// File: rtl/expmod_uart_bridge.sv
// UART command front-end for the modular-exponentiation engine: parses
// SYNC/OPCODE/operand frames, launches the engine and returns
// SYNC, status and the result bytes MSB-first.
module expmod_uart_bridge
    import expmod_uart_pkg::*;
#(
    parameter int         WIDTH     = 16,
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC,
    parameter int         TIMEOUT   = 1000000
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rx_valid_in,
    input  logic [7:0]       rx_byte_in,
    input  logic             tx_busy_in,
    output logic             tx_valid_out,
    output logic [7:0]       tx_byte_out,
    output logic             start_out,
    output logic [WIDTH-1:0] value_out,
    output logic [WIDTH-1:0] exponent_out,
    output logic [WIDTH-1:0] modulus_out,
    input  logic             busy_in,
    input  logic             done_in,
    input  logic [WIDTH-1:0] result_in,
    output logic             overrun_out
);

    localparam int NB = (WIDTH + 7) / 8;
    localparam int RW = NB * 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state;
    logic [CW-1:0]     byte_cnt;
    logic [1:0]        op_sel;
    logic              op_full;
    logic [7:0]        status;
    logic [RW-1:0]     tx_data;
    logic              tx_gap;
    logic [TO_W-1:0]   idle_cnt;
    logic              timed_out;
    logic              tx_ready;

    logic              is_op;
    logic              stg_clear;
    logic              ld_val;
    logic              ld_exp;
    logic              ld_mod;
    logic [WIDTH-1:0]  stg_val;
    logic [WIDTH-1:0]  stg_exp;
    logic [WIDTH-1:0]  stg_mod;

    // Value an operand takes once the byte on rx_byte_in is shifted into it.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] w, input logic [7:0] b);
        return WIDTH'({w, b});
    endfunction

    assign timed_out = (TIMEOUT != 0) && (idle_cnt == TO_LAST);
    // One idle cycle after every strobe lets the transmitter raise its busy flag.
    assign tx_ready  = !tx_gap && !tx_busy_in;

    // Staging control: clear on a valid opcode, load the operand being received.
    always_comb begin
        is_op     = (rx_byte_in == OP_FULL) || (rx_byte_in == OP_VALUE);
        stg_clear = (state == S_OPCODE) && rx_valid_in && is_op;
        ld_val    = (state == S_RX_OPS) && rx_valid_in && (op_sel == 2'd0);
        ld_exp    = (state == S_RX_OPS) && rx_valid_in && (op_sel == 2'd1);
        ld_mod    = (state == S_RX_OPS) && rx_valid_in && (op_sel == 2'd2);
    end

    byte_shift_assembler #(.WIDTH(WIDTH)) u_stg_val (
        .clk(clk_in), .rst(rst_in), .clear(stg_clear), .load(ld_val), .byte_in(rx_byte_in), .word(stg_val)
    );
    byte_shift_assembler #(.WIDTH(WIDTH)) u_stg_exp (
        .clk(clk_in), .rst(rst_in), .clear(stg_clear), .load(ld_exp), .byte_in(rx_byte_in), .word(stg_exp)
    );
    byte_shift_assembler #(.WIDTH(WIDTH)) u_stg_mod (
        .clk(clk_in), .rst(rst_in), .clear(stg_clear), .load(ld_mod), .byte_in(rx_byte_in), .word(stg_mod)
    );

    // Frame parser, engine handshake and TX serialiser with registered outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= S_IDLE;
            byte_cnt     <= '0;
            op_sel       <= '0;
            op_full      <= 1'b0;
            status       <= '0;
            tx_data      <= '0;
            tx_gap       <= 1'b0;
            idle_cnt     <= '0;
            tx_valid_out <= 1'b0;
            tx_byte_out  <= '0;
            start_out    <= 1'b0;
            value_out    <= '0;
            exponent_out <= '0;
            modulus_out  <= '0;
            overrun_out  <= 1'b0;
        end else begin
            start_out    <= 1'b0;
            tx_valid_out <= 1'b0;
            tx_gap       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_valid_in && (rx_byte_in == SYNC_BYTE)) begin
                        state    <= S_OPCODE;
                        idle_cnt <= '0;
                    end
                end
                S_OPCODE: begin
                    if (rx_valid_in) begin
                        idle_cnt <= '0;
                        if (is_op) begin
                            op_full  <= (rx_byte_in == OP_FULL);
                            op_sel   <= '0;
                            byte_cnt <= '0;
                            state    <= S_RX_OPS;
                        end else begin
                            status  <= ST_BAD_OPCODE;
                            tx_data <= '0;
                            state   <= S_TX_SYNC;
                        end
                    end else if (timed_out) begin
                        state <= S_IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                S_RX_OPS: begin
                    if (rx_valid_in) begin
                        idle_cnt <= '0;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                            // Live operands change only when the whole frame is in.
                            if (!op_full) begin
                                value_out <= shift_in(stg_val, rx_byte_in);
                                state     <= S_LAUNCH;
                            end else if (op_sel == 2'd2) begin
                                value_out    <= stg_val;
                                exponent_out <= stg_exp;
                                modulus_out  <= shift_in(stg_mod, rx_byte_in);
                                state        <= S_LAUNCH;
                            end else begin
                                op_sel <= op_sel + 2'd1;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end else if (timed_out) begin
                        state <= S_IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                S_LAUNCH: begin
                    if (modulus_out == '0) begin
                        status  <= ST_ZERO_MOD;
                        tx_data <= '0;
                        state   <= S_TX_SYNC;
                    end else if (!busy_in) begin
                        start_out <= 1'b1;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (done_in) begin
                        status  <= ST_OK;
                        tx_data <= RW'(result_in);
                        state   <= S_TX_SYNC;
                    end
                end
                S_TX_SYNC: begin
                    if (tx_ready) begin
                        tx_valid_out <= 1'b1;
                        tx_byte_out  <= SYNC_BYTE;
                        tx_gap       <= 1'b1;
                        state        <= S_TX_STATUS;
                    end
                end
                S_TX_STATUS: begin
                    if (tx_ready) begin
                        tx_valid_out <= 1'b1;
                        tx_byte_out  <= status;
                        tx_gap       <= 1'b1;
                        byte_cnt     <= '0;
                        state        <= S_TX_DATA;
                    end
                end
                S_TX_DATA: begin
                    if (tx_ready) begin
                        tx_valid_out <= 1'b1;
                        tx_byte_out  <= tx_data[RW-1 -: 8];
                        tx_data      <= tx_data << 8;
                        tx_gap       <= 1'b1;
                        if (byte_cnt == LAST_BYTE) begin
                            state <= S_IDLE;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (rx_valid_in && (state inside {S_LAUNCH, S_WAIT, S_TX_SYNC, S_TX_STATUS, S_TX_DATA})) begin
                overrun_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_expmod_uart_bridge.sv
// Bench for expmod_uart_bridge: a 16-bit and a 12-bit instance share one RX
// stream; each has its own engine stub and UART TX model.
module tb_expmod_uart_bridge;

    localparam int TMO = 50;

    typedef logic [7:0]  bq_t [$];
    typedef logic [47:0] oq_t [$];

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        tx_busy  [2];
    logic        tx_valid [2];
    logic [7:0]  tx_byte  [2];
    logic        start    [2];
    logic        busy     [2];
    logic        done     [2];
    logic        ovr      [2];
    logic [15:0] val16, exp16, mod16, res16;
    logic [11:0] val12, exp12, mod12, res12;
    logic [47:0] ops [2];
    logic [15:0] stub_res;

    int eng_cnt [2];
    int tx_cnt  [2];

    int checks   = 0;
    int failures = 0;

    bq_t         exp_tx    [2];
    bq_t         tx_log    [2];
    oq_t         exp_start [2];
    int          start_seen[2];
    logic [15:0] m_v [2];
    logic [15:0] m_e [2];
    logic [15:0] m_m [2];

    always #5 clk = ~clk;

    assign res16  = stub_res;
    assign res12  = stub_res[11:0];
    assign ops[0] = {val16, exp16, mod16};
    assign ops[1] = {4'h0, val12, 4'h0, exp12, 4'h0, mod12};
    assign tx_busy[0] = (tx_cnt[0] != 0);
    assign tx_busy[1] = (tx_cnt[1] != 0);

    expmod_uart_bridge #(.WIDTH(16), .SYNC_BYTE(8'hA5), .TIMEOUT(TMO)) u_dut16 (
        .clk_in(clk), .rst_in(rst), .rx_valid_in(rx_valid), .rx_byte_in(rx_byte),
        .tx_busy_in(tx_busy[0]), .tx_valid_out(tx_valid[0]), .tx_byte_out(tx_byte[0]),
        .start_out(start[0]), .value_out(val16), .exponent_out(exp16), .modulus_out(mod16),
        .busy_in(busy[0]), .done_in(done[0]), .result_in(res16), .overrun_out(ovr[0])
    );

    expmod_uart_bridge #(.WIDTH(12), .SYNC_BYTE(8'hA5), .TIMEOUT(TMO)) u_dut12 (
        .clk_in(clk), .rst_in(rst), .rx_valid_in(rx_valid), .rx_byte_in(rx_byte),
        .tx_busy_in(tx_busy[1]), .tx_valid_out(tx_valid[1]), .tx_byte_out(tx_byte[1]),
        .start_out(start[1]), .value_out(val12), .exponent_out(exp12), .modulus_out(mod12),
        .busy_in(busy[1]), .done_in(done[1]), .result_in(res12), .overrun_out(ovr[1])
    );

    // Engine stub: busy for 20 cycles after a start, then a one-cycle done.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                eng_cnt[d] <= 0;
                busy[d]    <= 1'b0;
                done[d]    <= 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                done[d] <= 1'b0;
                if (busy[d]) begin
                    if (eng_cnt[d] == 1) begin
                        busy[d] <= 1'b0;
                        done[d] <= 1'b1;
                    end
                    eng_cnt[d] <= eng_cnt[d] - 1;
                end else if (start[d]) begin
                    busy[d]    <= 1'b1;
                    eng_cnt[d] <= 20;
                end
            end
        end
    end

    // UART transmitter model: busy for a few cycles after each byte.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) tx_cnt[d] <= 0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (tx_valid[d]) tx_cnt[d] <= 4;
                else if (tx_cnt[d] != 0) tx_cnt[d] <= tx_cnt[d] - 1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Compare every TX strobe and start pulse against the model's queues.
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (tx_valid[d]) begin
                    tx_log[d].push_back(tx_byte[d]);
                    if (exp_tx[d].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL tx_unexpected dut%0d: got %0h want nothing", d, tx_byte[d]);
                    end else begin
                        check($sformatf("tx_byte_dut%0d", d), tx_byte[d], exp_tx[d].pop_front());
                    end
                end
                if (start[d]) begin
                    start_seen[d]++;
                    if (exp_start[d].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL start_unexpected dut%0d: got %0h want no start", d, ops[d]);
                    end else begin
                        check($sformatf("start_ops_dut%0d", d), ops[d], exp_start[d].pop_front());
                    end
                end
            end
        end
    end

    function automatic bq_t to_q(input logic [63:0] bytes, input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(bytes[(n-1-i)*8 +: 8]);
        return q;
    endfunction

    // Frame-level model: what each instance must start with and reply.
    task automatic model_frame(input bq_t fr);
        logic [15:0] mask;
        logic [15:0] r;
        logic [7:0]  st;
        for (int d = 0; d < 2; d++) begin
            mask = (d == 0) ? 16'hFFFF : 16'h0FFF;
            if (fr[1] == 8'h01 || fr[1] == 8'h02) begin
                m_v[d] = {fr[2], fr[3]} & mask;
                if (fr[1] == 8'h01) begin
                    m_e[d] = {fr[4], fr[5]} & mask;
                    m_m[d] = {fr[6], fr[7]} & mask;
                end
                if (m_m[d] == 16'h0) begin
                    st = 8'hE2;
                    r  = 16'h0;
                end else begin
                    st = 8'h00;
                    r  = stub_res & mask;
                    exp_start[d].push_back({m_v[d], m_e[d], m_m[d]});
                end
            end else begin
                st = 8'hE1;
                r  = 16'h0;
            end
            exp_tx[d].push_back(8'hA5);
            exp_tx[d].push_back(st);
            exp_tx[d].push_back(r[15:8]);
            exp_tx[d].push_back(r[7:0]);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        @(negedge clk);
    endtask

    task automatic send_packed(input logic [63:0] bytes, input int n);
        bq_t q;
        q = to_q(bytes, n);
        foreach (q[i]) send_byte(q[i]);
    endtask

    task automatic frame(input logic [63:0] bytes, input int n);
        model_frame(to_q(bytes, n));
        send_packed(bytes, n);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_tx[0].size() + exp_tx[1].size() + exp_start[0].size() + exp_start[1].size()) != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check({name, "_pending"}, exp_tx[0].size() + exp_tx[1].size() + exp_start[0].size() + exp_start[1].size(), 0);
        for (int d = 0; d < 2; d++) begin
            exp_tx[d].delete();
            exp_start[d].delete();
        end
        repeat (30) @(negedge clk);
    endtask

    task automatic clear_logs();
        for (int d = 0; d < 2; d++) tx_log[d].delete();
    endtask

    task automatic check_log(input string name, input int d, input logic [31:0] want);
        check({name, "_len"}, tx_log[d].size(), 4);
        if (tx_log[d].size() == 4) begin
            check(name, {tx_log[d][0], tx_log[d][1], tx_log[d][2], tx_log[d][3]}, want);
        end
    endtask

    task automatic check_all_zero(input string name);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_ops_dut%0d", name, d), ops[d], 0);
            check($sformatf("%s_ovr_dut%0d", name, d), ovr[d], 0);
            check($sformatf("%s_txv_dut%0d", name, d), tx_valid[d], 0);
            check($sformatf("%s_txb_dut%0d", name, d), tx_byte[d], 0);
            check($sformatf("%s_start_dut%0d", name, d), start[d], 0);
        end
    endtask

    initial begin
        int s0;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        stub_res = 16'h0000;
        for (int d = 0; d < 2; d++) begin
            m_v[d] = '0; m_e[d] = '0; m_m[d] = '0; start_seen[d] = 0;
        end
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full frame
        clear_logs();
        stub_res = 16'h1234;
        frame(64'hA5010005_00480431, 8);
        drain("t1");
        check("t1_val", val16, 16'h0005);
        check("t1_exp", exp16, 16'h0048);
        check("t1_mod", mod16, 16'h0431);
        check_log("t1_tx16", 0, 32'hA5001234);
        check_log("t1_tx12", 1, 32'hA5000234);
        check("t1_starts", start_seen[0], 1);

        // Value-only frame keeps exponent and modulus
        clear_logs();
        stub_res = 16'h0BEE;
        frame(64'hA5020007, 4);
        drain("t2");
        check("t2_val", val16, 16'h0007);
        check("t2_exp", exp16, 16'h0048);
        check("t2_mod", mod16, 16'h0431);
        check("t2_val12", val12, 12'h007);
        check_log("t2_tx16", 0, 32'hA5000BEE);
        check("t2_starts", start_seen[0], 2);

        // Noise byte, bad opcode, then zero modulus
        clear_logs();
        stub_res = 16'hFFFF;
        send_byte(8'h00);
        frame(64'hA57F, 2);
        drain("t3a");
        check_log("t3_bad_op16", 0, 32'hA5E10000);
        check_log("t3_bad_op12", 1, 32'hA5E10000);
        clear_logs();
        frame(64'hA5010002_00030000, 8);
        drain("t3b");
        check_log("t3_zero_mod", 0, 32'hA5E20000);
        check("t3_starts", start_seen[0], 2);
        check("t3_mod", mod16, 16'h0000);

        // Truncated frame times out silently
        clear_logs();
        send_packed(64'hA5010005, 4);
        repeat (TMO + 10) @(negedge clk);
        check("t4_no_tx", tx_log[0].size() + tx_log[1].size(), 0);
        stub_res = 16'h0051;
        frame(64'hA5010009_0002000D, 8);
        drain("t4");
        check_log("t4_tx", 0, 32'hA5000051);
        check("t4_val", val16, 16'h0009);
        check("t4_starts", start_seen[0], 3);

        // Byte during WAIT sets overrun, reply unaffected
        clear_logs();
        check("t5_ovr_before", ovr[0], 1'b0);
        stub_res = 16'h0777;
        frame(64'hA5010003_00040005, 8);
        repeat (5) @(negedge clk);
        send_byte(8'h55);
        drain("t5");
        check("t5_ovr16", ovr[0], 1'b1);
        check("t5_ovr12", ovr[1], 1'b1);
        check_log("t5_tx", 0, 32'hA5000777);

        // Reset during WAIT aborts with no reply
        clear_logs();
        stub_res = 16'h0999;
        s0 = start_seen[0];
        frame(64'hA5010003_00040005, 8);
        for (int i = 0; i < 40 && start_seen[0] == s0; i++) @(negedge clk);
        check("t5_rst_started", start_seen[0] - s0, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("t5_rst");
        for (int d = 0; d < 2; d++) begin
            exp_tx[d].delete();
            exp_start[d].delete();
            m_v[d] = '0; m_e[d] = '0; m_m[d] = '0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("t5_rst_no_tx", tx_log[0].size() + tx_log[1].size(), 0);

        // Pad bits of the first operand byte on the 12-bit instance
        clear_logs();
        stub_res = 16'h5ABC;
        frame(64'hA501F005_00030007, 8);
        drain("t6");
        check("t6_val12", val12, 12'h005);
        check("t6_val16", val16, 16'hF005);
        check("t6_exp12", exp12, 12'h003);
        check("t6_mod12", mod12, 12'h007);
        check_log("t6_tx12", 1, 32'hA5000ABC);
        check_log("t6_tx16", 0, 32'hA5005ABC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench still running at time limit");
        $fatal(1, "watchdog");
    end

endmodule
